// File: rtl/rv32_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32_decode_stage
// Purpose  : Registered RV32I decode stage between fetch and execute.
//            valid/ready handshake on both sides, one output register plus
//            one skid register so in_ready can be a flop. Each accepted word
//            becomes class / register indices / immediate / write-enable /
//            illegal flag. Supports flush and a saturating counter of
//            illegal instructions handed off to execute.
// Config   : `define RV32M_EN to decode funct7=0000001 OP encodings as
//            MULDIV (class 10); otherwise they are illegal (class 15).
// Ports    : clk, rst_n (sync, active-low), flush
//            in_valid / in_ready / in_instr / in_pc        : fetch side
//            out_valid / out_ready / out_pc / out_class /
//            out_funct3 / out_alt / out_rd / out_rs1 / out_rs2 /
//            out_imm / out_we / out_illegal                : execute side
//            illegal_cnt                                   : saturating count
// Revision : 1.0 - initial release
// ============================================================================
module rv32_decode_stage #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [3:0]       out_class,
  output logic [2:0]       out_funct3,
  output logic             out_alt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Major opcodes
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_system = 7'b1110011;

  // Operation classes
  localparam logic [3:0] c_cls_r      = 4'd0;
  localparam logic [3:0] c_cls_i      = 4'd1;
  localparam logic [3:0] c_cls_load   = 4'd2;
  localparam logic [3:0] c_cls_store  = 4'd3;
  localparam logic [3:0] c_cls_branch = 4'd4;
  localparam logic [3:0] c_cls_jal    = 4'd5;
  localparam logic [3:0] c_cls_jalr   = 4'd6;
  localparam logic [3:0] c_cls_lui    = 4'd7;
  localparam logic [3:0] c_cls_auipc  = 4'd8;
  localparam logic [3:0] c_cls_system = 4'd9;
  localparam logic [3:0] c_cls_muldiv = 4'd10;
  localparam logic [3:0] c_cls_ill    = 4'd15;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      cls;
    logic [2:0]      funct3;
    logic            alt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            we;
    logic            illegal;
  } dec_t;

  // --------------------------------------------------------------------------
  // Combinational decode of the word currently offered by fetch
  // --------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [3:0]  w_class;
  logic [31:0] w_imm;
  logic        w_alt;
  logic        w_writes;
  dec_t        w_dec;

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_sh;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  always_comb begin
    w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    w_imm_sh = {27'd0, in_instr[24:20]};
    w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                in_instr[30:25], in_instr[11:8], 1'b0};
    w_imm_u  = {in_instr[31:12], 12'd0};
    w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                in_instr[20], in_instr[30:21], 1'b0};
  end

  always_comb begin
    w_opcode = in_instr[6:0];
    w_f3     = in_instr[14:12];
    w_f7     = in_instr[31:25];
    w_class  = c_cls_ill;
    w_imm    = 32'd0;
    w_alt    = 1'b0;

    // Every listed opcode ends in 2'b11, so a bad low pair lands in default.
    case (w_opcode)
      c_op_reg: begin
        w_alt = in_instr[30];
        if (w_f7 == 7'b0000000)
          w_class = c_cls_r;
        else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))
          w_class = c_cls_r;
`ifdef RV32M_EN
        else if (w_f7 == 7'b0000001)
          w_class = c_cls_muldiv;
`endif
        else
          w_class = c_cls_ill;
      end
      c_op_imm: begin
        w_class = c_cls_i;
        w_imm   = w_imm_i;
        if (w_f3 == 3'b001) begin
          w_imm = w_imm_sh;
          if (w_f7 != 7'b0000000) w_class = c_cls_ill;
        end else if (w_f3 == 3'b101) begin
          w_imm = w_imm_sh;
          w_alt = in_instr[30];
          if (w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_class = c_cls_ill;
        end
      end
      c_op_load: begin
        w_imm   = w_imm_i;
        w_class = (w_f3 == 3'b011 || w_f3[2:1] == 2'b11) ? c_cls_ill : c_cls_load;
      end
      c_op_store: begin
        w_imm   = w_imm_s;
        w_class = (w_f3 > 3'b010) ? c_cls_ill : c_cls_store;
      end
      c_op_branch: begin
        w_imm   = w_imm_b;
        w_class = (w_f3[2:1] == 2'b01) ? c_cls_ill : c_cls_branch;
      end
      c_op_jal: begin
        w_imm   = w_imm_j;
        w_class = c_cls_jal;
      end
      c_op_jalr: begin
        w_imm   = w_imm_i;
        w_class = (w_f3 != 3'b000) ? c_cls_ill : c_cls_jalr;
      end
      c_op_lui: begin
        w_imm   = w_imm_u;
        w_class = c_cls_lui;
      end
      c_op_auipc: begin
        w_imm   = w_imm_u;
        w_class = c_cls_auipc;
      end
      c_op_system: begin
        w_imm   = w_imm_i;
        w_class = c_cls_system;
      end
      default: w_class = c_cls_ill;
    endcase

    case (w_class)
      c_cls_r, c_cls_i, c_cls_load, c_cls_jal, c_cls_jalr,
      c_cls_lui, c_cls_auipc, c_cls_muldiv: w_writes = 1'b1;
      default:                              w_writes = 1'b0;
    endcase

    w_dec.pc      = in_pc;
    w_dec.cls     = w_class;
    w_dec.funct3  = w_f3;
    w_dec.alt     = w_alt;
    w_dec.rd      = in_instr[11:7];
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.imm     = w_imm;
    w_dec.we      = w_writes && (in_instr[11:7] != 5'd0);
    w_dec.illegal = (w_class == c_cls_ill);
  end

  // --------------------------------------------------------------------------
  // Output register + skid register
  // --------------------------------------------------------------------------
  dec_t             r_out;
  dec_t             r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_handoff;
  logic w_out_free;

  always_comb begin
    w_accept   = in_valid && r_in_ready;
    w_handoff  = r_out_valid && out_ready;
    w_out_free = !r_out_valid || out_ready;
  end

  // in_ready is simply !skid_valid held in its own flop. Since a full skid
  // forces in_ready low, accepting and refilling from skid never coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_cnt        <= '0;
    end else begin
      // Counting is independent of flush: a handoff in the flush cycle counts.
      if (w_handoff && r_out.illegal && r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + c_cnt_one;

      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_out_free) begin
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_accept) begin
          r_out       <= w_dec;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        // Output stalled: park the new word so fetch is not back-pressured
        // combinationally.
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out.pc;
  assign out_class   = r_out.cls;
  assign out_funct3  = r_out.funct3;
  assign out_alt     = r_out.alt;
  assign out_rd      = r_out.rd;
  assign out_rs1     = r_out.rs1;
  assign out_rs2     = r_out.rs2;
  assign out_imm     = r_out.imm;
  assign out_we      = r_out.we;
  assign out_illegal = r_out.illegal;
  assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_decode_stage
// Purpose  : Self-checking bench for rv32_decode_stage. A queue-based model
//            of the two-deep stage plus an arithmetic decoder provide the
//            expected outputs; directed instructions pin literal values.
// Config   : honours `RV32M_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_decode_stage;

  localparam int PC_W    = 32;
  localparam int CNT_W   = 4;   // small so saturation is reachable
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [3:0]       out_class;
  logic [2:0]       out_funct3;
  logic             out_alt;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [31:0]      out_imm;
  logic             out_we;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  rv32_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_class(out_class), .out_funct3(out_funct3), .out_alt(out_alt),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_we(out_we), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference decoder: immediates built with plain arithmetic
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    int          cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] x, input logic [31:0] pc);
    dec_t d;
    bit   bad = 1'b0;
    bit   wr  = 1'b0;
    int   f3  = int'(x[14:12]);
    int   f7  = int'(x[31:25]);
    int   i_imm = $signed(x) >>> 20;
    int   s_imm = (($signed(x) >>> 25) * 32) + int'(x[11:7]);
    int   b_imm = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32
                  + int'(x[11:8]) * 2;
    int   j_imm = (x[31] ? -(1 << 20) : 0) + int'(x[19:12]) * 4096
                  + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
    int   u_imm = int'(x & 32'hFFFF_F000);
    d.pc = pc; d.f3 = x[14:12]; d.rd = x[11:7]; d.rs1 = x[19:15]; d.rs2 = x[24:20];
    d.alt = 1'b0; d.imm = 32'd0; d.cls = 15;
    case (int'(x[6:0]))
      'h33: begin
        d.alt = x[30];
        if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) begin d.cls = 0; wr = 1; end
        else if (f7 == 1 && M_EN) begin d.cls = 10; wr = 1; end
        else bad = 1;
      end
      'h13: begin
        d.cls = 1; wr = 1;
        if (f3 == 1 || f3 == 5) begin
          d.imm = {27'd0, x[24:20]};
          if (f3 == 5) d.alt = x[30];
          bad = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 32);
        end else d.imm = i_imm;
      end
      'h03: begin d.cls = 2; wr = 1; d.imm = i_imm; bad = (f3 == 3 || f3 >= 6); end
      'h23: begin d.cls = 3; d.imm = s_imm; bad = (f3 > 2); end
      'h63: begin d.cls = 4; d.imm = b_imm; bad = (f3 == 2 || f3 == 3); end
      'h6F: begin d.cls = 5; wr = 1; d.imm = j_imm; end
      'h67: begin d.cls = 6; wr = 1; d.imm = i_imm; bad = (f3 != 0); end
      'h37: begin d.cls = 7; wr = 1; d.imm = u_imm; end
      'h17: begin d.cls = 8; wr = 1; d.imm = u_imm; end
      'h73: begin d.cls = 9; d.imm = i_imm; end
      default: bad = 1;
    endcase
    if (bad) d.cls = 15;
    d.ill = bad;
    d.we  = !bad && wr && (x[11:7] != 5'd0);
    return d;
  endfunction

  // --------------------------------------------------------------------------
  // Stage model: a FIFO of at most two decoded entries
  // --------------------------------------------------------------------------
  dec_t q[$];
  bit   m_ready = 1'b1;
  int   m_cnt   = 0;
  bit   m_init  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ready = 1'b1;
      m_cnt   = 0;
      m_init  = 1'b1;
    end else if (m_init) begin
      if (q.size() > 0 && out_ready) begin
        if (q[0].ill && m_cnt < CNT_MAX) m_cnt++;
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
        m_ready = 1'b1;
      end else begin
        if (in_valid && m_ready) q.push_back(ref_decode(in_instr, in_pc));
        m_ready = (q.size() < 2);
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("illegal_cnt", {28'd0, illegal_cnt}, m_cnt);
      if (q.size() > 0 && out_valid) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_class", {28'd0, out_class}, q[0].cls);
        chk("out_funct3", {29'd0, out_funct3}, {29'd0, q[0].f3});
        chk("out_alt", {31'd0, out_alt}, {31'd0, q[0].alt});
        chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        chk("out_rs1", {27'd0, out_rs1}, {27'd0, q[0].rs1});
        chk("out_rs2", {27'd0, out_rs2}, {27'd0, q[0].rs2});
        chk("out_imm", out_imm, q[0].imm);
        chk("out_we", {31'd0, out_we}, {31'd0, q[0].we});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
      end
    end
  end

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;
      6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
      9: w[6:0] = 7'h73;  default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int exp_cnt;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = '0;
    repeat (3) step();

    // Reset state
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_pc", out_pc, 32'd0);
    chk("rst out_imm", out_imm, 32'd0);
    chk("rst out_class", {28'd0, out_class}, 32'd0);
    chk("rst illegal_cnt", {28'd0, illegal_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // ADDI x1,x0,5
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    step();
    chk("addi valid", {31'd0, out_valid}, 32'd1);
    chk("addi class", {28'd0, out_class}, 32'd1);
    chk("addi rd", {27'd0, out_rd}, 32'd1);
    chk("addi rs1", {27'd0, out_rs1}, 32'd0);
    chk("addi imm", out_imm, 32'h0000_0005);
    chk("addi we", {31'd0, out_we}, 32'd1);
    chk("addi illegal", {31'd0, out_illegal}, 32'd0);

    // SUB x3,x1,x2
    in_instr = 32'h4020_81B3; in_pc = 32'h104;
    step();
    chk("sub class", {28'd0, out_class}, 32'd0);
    chk("sub funct3", {29'd0, out_funct3}, 32'd0);
    chk("sub alt", {31'd0, out_alt}, 32'd1);
    chk("sub rd", {27'd0, out_rd}, 32'd3);
    chk("sub rs1", {27'd0, out_rs1}, 32'd1);
    chk("sub rs2", {27'd0, out_rs2}, 32'd2);
    chk("sub imm", out_imm, 32'd0);

    // BEQ x0,x0,-4
    in_instr = 32'hFE00_0EE3; in_pc = 32'h108;
    step();
    chk("beq class", {28'd0, out_class}, 32'd4);
    chk("beq imm", out_imm, 32'hFFFF_FFFC);
    chk("beq we", {31'd0, out_we}, 32'd0);

    // MUL x3,x1,x2
    in_instr = 32'h0220_81B3; in_pc = 32'h10C;
    step();
    in_valid = 1'b0;
    chk("mul class", {28'd0, out_class}, M_EN ? 32'd10 : 32'd15);
    chk("mul we", {31'd0, out_we}, M_EN ? 32'd1 : 32'd0);
    chk("mul illegal", {31'd0, out_illegal}, M_EN ? 32'd0 : 32'd1);
    step();
    exp_cnt = M_EN ? 0 : 1;
    chk("mul cnt", {28'd0, illegal_cnt}, exp_cnt);

    // Backpressure: three back-to-back offers with execute stalled
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0010_0113; in_pc = 32'h200; step();   // ADDI x2,x0,1
    chk("bp ready1", {31'd0, in_ready}, 32'd1);
    in_instr = 32'h0020_0193; in_pc = 32'h204; step();   // ADDI x3,x0,2
    chk("bp ready2", {31'd0, in_ready}, 32'd0);
    in_instr = 32'h0030_0213; in_pc = 32'h208; step();   // ADDI x4,x0,3 (refused)
    chk("bp ready3", {31'd0, in_ready}, 32'd0);
    chk("bp head pc", out_pc, 32'h200);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("bp second pc", out_pc, 32'h204);
    chk("bp second valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp drained", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and an offer in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0000_0000; in_pc = 32'h300; step();   // illegal, stuck at output
    in_instr = 32'h0050_0093; in_pc = 32'h304; step();
    in_instr = 32'h0060_0093; in_pc = 32'h308; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush cnt", {28'd0, illegal_cnt}, exp_cnt);
    repeat (3) step();
    chk("flush no ghost", {31'd0, out_valid}, 32'd0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = ($urandom_range(0, 2) == 0) ? 32'h0000_0000 : gen_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = (i < 3000) ? ($urandom_range(0, 499) != 0) : 1'b1;
      step();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("cnt saturated", {28'd0, illegal_cnt}, CNT_MAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
